// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master (fetch / MEM) to one-slave SRAM-style bus arbiter.
// A master that sees bus_addr_ok=0 keeps the bus until its request is
// accepted or withdrawn. Accepted transactions are remembered in a small
// in-order FIFO of master ids so slave responses are steered back to the
// right master with zero added latency.
// Optional feature: define SRAM_ARB_RR_EN for round-robin selection when the
// bus is free; the default build uses fixed data-first priority.
module sram_arbiter #(
  parameter int DEPTH = 4  // outstanding transactions; power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // MEM side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared slave
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;      // 0 = inst, 1 = data
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          resp_err_q, resp_err_d;
  logic          fifo_q [DEPTH];        // id of each outstanding transaction

  logic idle_sel;    // choice when no master holds the bus
  logic sel;         // master currently driving the bus
  logic sel_req;
  logic fifo_full;
  logic fifo_empty;
  logic req_ok;      // bus_req before output gating
  logic push;
  logic pop;
  logic head;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;

  // Remember who won the most recent accepted handshake; reset favours data.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else if (push) begin
      last_grant_q <= sel;
    end
  end

  // Round-robin on a tie, otherwise the lone requester wins.
  always_comb begin
    if (inst_req && data_req) begin
      idle_sel = ~last_grant_q;
    end else begin
      idle_sel = data_req;
    end
  end
`else
  // Fixed priority: data whenever it asks.
  assign idle_sel = data_req;
`endif

  assign sel     = (state_q == LOCKED) ? grant_q : idle_sel;
  assign sel_req = sel ? data_req : inst_req;
  // Full is taken from the registered count, so a same-cycle pop cannot
  // open the bus; the freed slot is used one cycle later.
  assign req_ok  = sel_req & ~fifo_full & ~rst;
  assign push    = req_ok & bus_addr_ok;
  assign pop     = bus_data_ok & ~fifo_empty & ~rst;
  assign head    = fifo_q[rptr_q];

  // State register: arbitration state and locked grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state: lock onto a master the slave stalls, release on accept or withdrawal.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (req_ok && !bus_addr_ok) begin
          state_d = LOCKED;
          grant_d = sel;
        end
      end
      LOCKED: begin
        // While full the lock is frozen so the stalled master keeps priority.
        if (!fifo_full && (!sel_req || bus_addr_ok)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: payload mux, handshake steering and response routing; all zero in reset.
  always_comb begin
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = '0;
    bus_addr     = '0;
    bus_wstrb    = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    resp_err     = 1'b0;
    if (!rst) begin
      bus_req      = req_ok;
      bus_wr       = sel ? data_wr    : inst_wr;
      bus_size     = sel ? data_size  : inst_size;
      bus_addr     = sel ? data_addr  : inst_addr;
      bus_wstrb    = sel ? data_wstrb : inst_wstrb;
      bus_wdata    = sel ? data_wdata : inst_wdata;
      inst_addr_ok = push & ~sel;
      data_addr_ok = push & sel;
      inst_data_ok = pop & ~head;
      data_data_ok = pop & head;
      inst_rdata   = bus_rdata;
      data_rdata   = bus_rdata;
      resp_err     = resp_err_q;
    end
  end

  // Response-order FIFO bookkeeping and sticky stray-response flag.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q | (bus_data_ok & fifo_empty & ~rst);
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
    end
  end

  // FIFO storage: entries are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter (DEPTH=4,
// default fixed-priority build). Stimulus pushes expected accepts and
// responses into queues; a negedge monitor pops and compares them.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  sram_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .resp_err(resp_err)
  );

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  grant_t mg;
  resp_t  mr;
  int     nchk  = 0;
  int     npass = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endfunction

  // Monitor: every accept and every response must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_addr_ok || data_addr_ok) begin
        check("addr_ok exclusive", 32'(inst_addr_ok & data_addr_ok), 32'd0);
        if (gq.size() == 0) begin
          check("unexpected accept", 32'd1, 32'd0);
        end else begin
          mg = gq.pop_front();
          check("grant id", 32'(data_addr_ok), 32'(mg.id));
          check("bus_addr", bus_addr, mg.addr);
          check("bus_wr", 32'(bus_wr), 32'(mg.wr));
          check("bus_wdata", bus_wdata, mg.wdata);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        check("data_ok exclusive", 32'(inst_data_ok & data_data_ok), 32'd0);
        if (rq.size() == 0) begin
          check("unexpected data_ok", 32'd1, 32'd0);
        end else begin
          mr = rq.pop_front();
          check("resp id", 32'(data_data_ok), 32'(mr.id));
          check("rdata", data_data_ok ? data_rdata : inst_rdata, mr.rdata);
        end
      end
    end
  end

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    next();
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr, input logic wr);
    inst_req   = req;
    inst_addr  = addr;
    inst_wr    = wr;
    inst_wdata = ~addr;
    inst_size  = 2'd2;
    inst_wstrb = 4'hf;
  endtask

  task automatic set_data(input logic req, input logic [31:0] addr, input logic wr);
    data_req   = req;
    data_addr  = addr;
    data_wr    = wr;
    data_wdata = addr ^ 32'h5a5a5a5a;
    data_size  = 2'd1;
    data_wstrb = 4'h3;
  endtask

  task automatic clear_reqs();
    set_inst(1'b0, 32'd0, 1'b0);
    set_data(1'b0, 32'd0, 1'b0);
  endtask

  task automatic expect_grant(input logic id, input logic [31:0] addr, input logic wr);
    grant_t g;
    g.id    = id;
    g.addr  = addr;
    g.wr    = wr;
    g.wdata = id ? (addr ^ 32'h5a5a5a5a) : ~addr;
    gq.push_back(g);
  endtask

  task automatic expect_resp(input logic id, input logic [31:0] rdata);
    resp_t r;
    r.id    = id;
    r.rdata = rdata;
    rq.push_back(r);
  endtask

  // One slave response cycle whose routing is known in advance.
  task automatic respond(input logic id, input logic [31:0] rdata);
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    expect_resp(id, rdata);
    step();
    bus_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_reqs();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'd0;
    next();

    // Reset cycle with every input active: all outputs must read zero.
    set_inst(1'b1, 32'h1c000000, 1'b0);
    set_data(1'b1, 32'h80000000, 1'b0);
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hdeadbeef;
    settle();
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    check("rst data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst rdata", inst_rdata | data_rdata, 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    next();
    rst = 1'b0;
    bus_data_ok = 1'b0;

    // Both request at release: data first, then inst.
    expect_grant(1'b1, 32'h80000000, 1'b0);
    step();
    set_data(1'b0, 32'd0, 1'b0);
    expect_grant(1'b0, 32'h1c000000, 1'b0);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    respond(1'b1, 32'ha1a1a1a1);
    respond(1'b0, 32'ha2a2a2a2);

    // Stalled inst keeps the bus while data arrives, data follows.
    set_inst(1'b1, 32'h1c000000, 1'b0);
    settle();
    check("stall bus_req", 32'(bus_req), 32'd1);
    check("stall bus_addr c1", bus_addr, 32'h1c000000);
    next();
    set_data(1'b1, 32'h80000040, 1'b1);
    settle();
    check("locked bus_addr c2", bus_addr, 32'h1c000000);
    check("locked data_addr_ok", 32'(data_addr_ok), 32'd0);
    next();
    settle();
    check("locked bus_addr c3", bus_addr, 32'h1c000000);
    next();
    bus_addr_ok = 1'b1;
    expect_grant(1'b0, 32'h1c000000, 1'b0);
    step();
    set_inst(1'b0, 32'd0, 1'b0);
    expect_grant(1'b1, 32'h80000040, 1'b1);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    respond(1'b0, 32'hb1b1b1b1);
    respond(1'b1, 32'hb2b2b2b2);

    // Fixed priority: data keeps winning ties while it keeps asking.
    bus_addr_ok = 1'b1;
    set_inst(1'b1, 32'h1c000100, 1'b0);
    set_data(1'b1, 32'h80000100, 1'b0);
    expect_grant(1'b1, 32'h80000100, 1'b0);
    step();
    set_data(1'b1, 32'h80000104, 1'b0);
    expect_grant(1'b1, 32'h80000104, 1'b0);
    step();
    set_data(1'b0, 32'd0, 1'b0);
    expect_grant(1'b0, 32'h1c000100, 1'b0);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    respond(1'b1, 32'hc1c1c1c1);
    respond(1'b1, 32'hc2c2c2c2);
    respond(1'b0, 32'hc3c3c3c3);

    // Fill the FIFO: 5th request is held off until a pop frees a slot.
    bus_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_data(1'b1, 32'h100 + 32'(4 * i), 1'b0);
      expect_grant(1'b1, 32'h100 + 32'(4 * i), 1'b0);
      step();
    end
    set_data(1'b1, 32'h110, 1'b0);
    settle();
    check("full bus_req", 32'(bus_req), 32'd0);
    check("full data_addr_ok", 32'(data_addr_ok), 32'd0);
    next();
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hd0d0d0d0;
    expect_resp(1'b1, 32'hd0d0d0d0);
    settle();
    check("full pop bus_req", 32'(bus_req), 32'd0);
    next();
    bus_data_ok = 1'b0;
    expect_grant(1'b1, 32'h110, 1'b0);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    respond(1'b1, 32'hd1d1d1d1);
    respond(1'b1, 32'hd2d2d2d2);
    respond(1'b1, 32'hd3d3d3d3);
    respond(1'b1, 32'hd4d4d4d4);

    // In-order return across masters.
    bus_addr_ok = 1'b1;
    set_inst(1'b1, 32'h1c000010, 1'b0);
    expect_grant(1'b0, 32'h1c000010, 1'b0);
    step();
    set_inst(1'b0, 32'd0, 1'b0);
    set_data(1'b1, 32'h80000010, 1'b0);
    expect_grant(1'b1, 32'h80000010, 1'b0);
    step();
    set_data(1'b0, 32'd0, 1'b0);
    set_inst(1'b1, 32'h1c000014, 1'b0);
    expect_grant(1'b0, 32'h1c000014, 1'b0);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    respond(1'b0, 32'h11);
    respond(1'b1, 32'h22);
    respond(1'b0, 32'h33);

    // Locked master withdraws: no issue that cycle, data wins afterwards.
    set_inst(1'b1, 32'h1c000200, 1'b0);
    step();
    set_inst(1'b0, 32'd0, 1'b0);
    set_data(1'b1, 32'h80000200, 1'b0);
    settle();
    check("withdraw bus_req", 32'(bus_req), 32'd0);
    check("withdraw data_addr_ok", 32'(data_addr_ok), 32'd0);
    next();
    bus_addr_ok = 1'b1;
    expect_grant(1'b1, 32'h80000200, 1'b0);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    respond(1'b1, 32'he1e1e1e1);

    // Pointer wrap: 10 alternating requests, one response per cycle.
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        bus_addr_ok = 1'b1;
        if (k % 2 == 0) begin
          set_inst(1'b1, 32'h1c000300 + 32'(4 * k), 1'b0);
          set_data(1'b0, 32'd0, 1'b0);
          expect_grant(1'b0, 32'h1c000300 + 32'(4 * k), 1'b0);
        end else begin
          set_inst(1'b0, 32'd0, 1'b0);
          set_data(1'b1, 32'h80000300 + 32'(4 * k), 1'b0);
          expect_grant(1'b1, 32'h80000300 + 32'(4 * k), 1'b0);
        end
      end else begin
        clear_reqs();
        bus_addr_ok = 1'b0;
      end
      if (k >= 1) begin
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hf00 + 32'(k - 1);
        expect_resp(((k - 1) % 2) == 1, 32'hf00 + 32'(k - 1));
      end else begin
        bus_data_ok = 1'b0;
      end
      settle();
      if (k < 10) check("wrap bus_req", 32'(bus_req), 32'd1);
      next();
    end
    bus_data_ok = 1'b0;

    // Stray response with nothing outstanding.
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h77;
    settle();
    check("stray data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next();
    bus_data_ok = 1'b0;
    settle();
    check("stray resp_err", 32'(resp_err), 32'd1);
    next();
    settle();
    check("resp_err sticky", 32'(resp_err), 32'd1);
    next();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("resp_err cleared", 32'(resp_err), 32'd0);
    next();

    // Reset discards an outstanding transaction.
    bus_addr_ok = 1'b1;
    set_inst(1'b1, 32'h1c000400, 1'b0);
    expect_grant(1'b0, 32'h1c000400, 1'b0);
    step();
    clear_reqs();
    bus_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h99;
    settle();
    check("discarded data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next();
    bus_data_ok = 1'b0;
    settle();
    check("discarded resp_err", 32'(resp_err), 32'd1);
    next();

    check("grant queue drained", 32'(gq.size()), 32'd0);
    check("resp queue drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
